// File: rtl/timer_seq_controller.sv
// timer_seq_controller: searches a serial stream for 1101, then sequences the
// downstream shift/count register: shift_en for SHIFT_CYCLES cycles, count_en
// until done_counting, then done until the host acks.
module timer_seq_controller #(
    parameter int SHIFT_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_data,
    input  logic i_done_counting,
    input  logic i_ack,
    output logic o_shift_en,
    output logic o_count_en,
    output logic o_done,
    output logic o_busy
);

    localparam int CW = $clog2(SHIFT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S0, S1, S11, S110, SHIFT, COUNT, WAIT_ACK
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    // State and shift-counter registers; reset wins over every transition.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: overlapping 1101 search, then shift/count/ack sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S0:   w_state_nxt = i_data ? S1  : S0;
            S1:   w_state_nxt = i_data ? S11 : S0;
            S11:  w_state_nxt = i_data ? S11 : S110;
            S110: begin
                if (i_data) begin
                    w_state_nxt = SHIFT;
                    // counter holds the number of SHIFT cycles still to come
                    w_cnt_nxt   = CW'(SHIFT_CYCLES - 1);
                end else begin
                    w_state_nxt = S0;
                end
            end
            SHIFT: begin
                if (r_cnt == '0) w_state_nxt = COUNT;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            COUNT:    if (i_done_counting) w_state_nxt = WAIT_ACK;
            WAIT_ACK: if (i_ack)           w_state_nxt = S0;
            default:  w_state_nxt = S0;
        endcase
    end

    // Moore outputs decoded straight from the state register.
    assign o_shift_en = (r_state == SHIFT);
    assign o_count_en = (r_state == COUNT);
    assign o_done     = (r_state == WAIT_ACK);
    assign o_busy     = (r_state == SHIFT) || (r_state == COUNT) || (r_state == WAIT_ACK);

endmodule

// File: tb/tb_timer_seq_controller.sv
// Directed bench for timer_seq_controller; output vector is {shift,count,done,busy}.
module tb_timer_seq_controller;

    logic clk = 1'b0;
    logic reset_n, data, done_counting, ack;
    logic shift_en, count_en, done, busy;
    logic shift_en1, count_en1, done1, busy1;
    int   total = 0;
    int   bad   = 0;

    timer_seq_controller #(.SHIFT_CYCLES(4)) u_dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_data(data),
        .i_done_counting(done_counting), .i_ack(ack),
        .o_shift_en(shift_en), .o_count_en(count_en), .o_done(done), .o_busy(busy)
    );

    timer_seq_controller #(.SHIFT_CYCLES(1)) u_dut1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_data(data),
        .i_done_counting(done_counting), .i_ack(ack),
        .o_shift_en(shift_en1), .o_count_en(count_en1), .o_done(done1), .o_busy(busy1)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] IDLE = 4'b0000;
    localparam logic [3:0] SHF  = 4'b1001;
    localparam logic [3:0] CNT  = 4'b0101;
    localparam logic [3:0] WAK  = 4'b0011;

    // advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] o4();
        return {shift_en, count_en, done, busy};
    endfunction

    function automatic logic [3:0] o1();
        return {shift_en1, count_en1, done1, busy1};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; data = 1'b0; ack = 1'b0;
        tick();
        chk("reset", o4(), IDLE);
        reset_n = 1'b1;
    endtask

    // feed 1,1,0 then final 1; outputs stay idle until the final edge
    task automatic feed_1101(input string tag);
        data = 1'b1; tick(); chk({tag, "_b1"}, o4(), IDLE);
        data = 1'b1; tick(); chk({tag, "_b2"}, o4(), IDLE);
        data = 1'b0; tick(); chk({tag, "_b3"}, o4(), IDLE);
        data = 1'b1; tick(); chk({tag, "_det"}, o4(), SHF);
        data = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; data = 1'b0; done_counting = 1'b0; ack = 1'b0;
        tick(); tick();
        chk("reset_idle", o4(), IDLE);
        chk("reset_idle_v1", o1(), IDLE);
        reset_n = 1'b1;

        // basic detection, 4 shift cycles, 11 count cycles, 6 done cycles
        feed_1101("t1");
        for (int i = 0; i < 3; i++) begin tick(); chk("t1_shift", o4(), SHF); end
        tick(); chk("t1_count_first", o4(), CNT);
        for (int i = 0; i < 10; i++) begin tick(); chk("t1_count_hold", o4(), CNT); end
        done_counting = 1'b1; tick(); chk("t1_done_rise", o4(), WAK);
        done_counting = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); chk("t1_done_hold", o4(), WAK); end
        ack = 1'b1; tick(); chk("t1_ack", o4(), IDLE);
        ack = 1'b0; tick(); chk("t1_idle_after", o4(), IDLE);

        // overlap 11101
        data = 1'b1; tick(); chk("ov1_b1", o4(), IDLE);
        tick(); chk("ov1_b2", o4(), IDLE);
        tick(); chk("ov1_b3", o4(), IDLE);
        data = 1'b0; tick(); chk("ov1_b4", o4(), IDLE);
        data = 1'b1; tick(); chk("ov1_det", o4(), SHF);
        data = 1'b0;
        do_reset();

        // 11001101 detects only on the 8th bit
        data = 1'b1; tick(); chk("ov2_b1", o4(), IDLE);
        data = 1'b1; tick(); chk("ov2_b2", o4(), IDLE);
        data = 1'b0; tick(); chk("ov2_b3", o4(), IDLE);
        data = 1'b0; tick(); chk("ov2_b4", o4(), IDLE);
        data = 1'b1; tick(); chk("ov2_b5", o4(), IDLE);
        data = 1'b1; tick(); chk("ov2_b6", o4(), IDLE);
        data = 1'b0; tick(); chk("ov2_b7", o4(), IDLE);
        data = 1'b1; tick(); chk("ov2_det", o4(), SHF);
        data = 1'b0;

        // done_counting held high from reset: single count cycle, no retrigger
        done_counting = 1'b1;
        do_reset();
        feed_1101("dc");
        for (int i = 0; i < 3; i++) begin tick(); chk("dc_shift", o4(), SHF); end
        tick(); chk("dc_count_pulse", o4(), CNT);
        tick(); chk("dc_done", o4(), WAK);
        data = 1'b1; tick(); chk("dc_nr1", o4(), WAK);
        data = 1'b1; tick(); chk("dc_nr2", o4(), WAK);
        data = 1'b0; tick(); chk("dc_nr3", o4(), WAK);
        data = 1'b1; tick(); chk("dc_nr4", o4(), WAK);
        data = 1'b0; tick(); chk("dc_nr5", o4(), WAK);
        ack = 1'b1; tick(); chk("dc_ack", o4(), IDLE);
        ack = 1'b0; tick(); chk("dc_idle", o4(), IDLE);
        done_counting = 1'b0;

        // reset during the 2nd shift cycle, then a fresh full sequence
        feed_1101("rs");
        tick(); chk("rs_shift2", o4(), SHF);
        reset_n = 1'b0; tick(); chk("rs_reset", o4(), IDLE);
        reset_n = 1'b1; tick(); chk("rs_idle", o4(), IDLE);
        feed_1101("rs2");
        for (int i = 0; i < 3; i++) begin tick(); chk("rs2_shift", o4(), SHF); end
        tick(); chk("rs2_count", o4(), CNT);

        // done_counting and ack together in COUNT: only done_counting acts
        done_counting = 1'b1; ack = 1'b1;
        tick(); chk("sim_done", o4(), WAK);
        done_counting = 1'b0;
        tick(); chk("sim_ack", o4(), IDLE);
        ack = 1'b0;

        // SHIFT_CYCLES=1 instance
        do_reset();
        data = 1'b1; tick(); chk("v1_b1", o1(), IDLE);
        data = 1'b1; tick(); chk("v1_b2", o1(), IDLE);
        data = 1'b0; tick(); chk("v1_b3", o1(), IDLE);
        data = 1'b1; tick(); chk("v1_shift", o1(), SHF);
        data = 1'b0; tick(); chk("v1_count", o1(), CNT);
        tick(); chk("v1_count_hold", o1(), CNT);
        done_counting = 1'b1; tick(); chk("v1_done", o1(), WAK);
        done_counting = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
